lc3b_control: RTL
=================

LC3B_CONTROL -- requirements
Module: lc3b_control

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 The block SHALL have no parameters; all widths come from the shared package.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 opcode  input  lc3b_opcode (4)  IR[15:12] from the datapath.
REQ-006 imm_sel  input  1  IR[5]; 1 = immediate operand for ADD/AND.
REQ-007 branch_enable  input  1  nzp compare result from the datapath.
REQ-008 mem_resp  input  1  memory completion strobe, one cycle.
REQ-009 load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  output  1 each  datapath register loads.
REQ-010 pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel  output  1 each  datapath mux selects.
REQ-011 aluop  output  lc3b_aluop (3)  ALU operation.
REQ-012 mem_read, mem_write  output  1 each  memory request strobes.
REQ-013 mem_byte_enable  output  2  byte lanes; 2'b11 whenever mem_write=1, else 2'b00.

Function
REQ-014 The block SHALL be a Moore FSM: all outputs decode from the current state only, except the mem_resp-driven transitions.
REQ-015 States SHALL be IDLE, FETCH1, FETCH2, FETCH3, DECODE, S_ADD, S_AND, S_NOT, BR, BR_TAKEN, CALC_ADDR, LDR1, LDR2, STR1, STR2.
REQ-016 Every output SHALL default to 0 (aluop=ALU_ADD) in any state not listed below.
REQ-017 IDLE: all outputs 0; next state FETCH1 unconditionally.
REQ-018 FETCH1: marmux_sel=1, load_mar=1, load_pc=1, pcmux_sel=0; next FETCH2.
REQ-019 FETCH2: mem_read=1, mdrmux_sel=1, load_mdr=1; stays in FETCH2 until mem_resp=1, then FETCH3.
REQ-020 FETCH3: load_ir=1; next DECODE.
REQ-021 DECODE: no outputs; ADD->S_ADD, AND->S_AND, NOT->S_NOT, BR->BR, LDR/STR->CALC_ADDR; any other opcode -> FETCH1 (treated as NOP).
REQ-022 S_ADD/S_AND: aluop=ALU_ADD/ALU_AND, alumux_sel=imm_sel, load_regfile=1, load_cc=1, regfilemux_sel=0; next FETCH1.
REQ-023 S_NOT: aluop=ALU_NOT, load_regfile=1, load_cc=1; next FETCH1.
REQ-024 BR: no outputs; branch_enable=1 -> BR_TAKEN, else FETCH1.
REQ-025 BR_TAKEN: pcmux_sel=1, load_pc=1; next FETCH1.
REQ-026 CALC_ADDR: alumux_sel=1, aluop=ALU_ADD, load_mar=1; LDR->LDR1, STR->STR1.
REQ-027 LDR1: mem_read=1, mdrmux_sel=1, load_mdr=1; holds until mem_resp, then LDR2.
REQ-028 LDR2: regfilemux_sel=1, load_regfile=1, load_cc=1; next FETCH1.
REQ-029 STR1: storemux_sel=1, aluop=ALU_PASS, load_mdr=1, mdrmux_sel=0; next STR2.
REQ-030 STR2: mem_write=1; holds until mem_resp, then FETCH1.
REQ-031 mem_read/mem_write SHALL stay asserted and stable for the entire wait; a mem_resp arriving in a non-memory state SHALL be ignored.
REQ-032 mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-033 Minimum latency SHALL be 5 cycles per ALU instruction, from FETCH1 back to FETCH1 with mem_resp in the first wait cycle.

Reset
REQ-034 rst_n=0 SHALL force IDLE immediately, regardless of clock, including mid memory wait; all outputs are then 0.
REQ-035 The first rising edge after rst_n deasserts SHALL move IDLE->FETCH1.

Structure
REQ-036 lc3b_opcode and lc3b_aluop enums SHALL live in lc3b_types; the state enum SHALL be local to the module.
REQ-037 The block SHALL be one module with no sub-modules: next-state logic, output decode and state register.

Verification
REQ-038 Reset: rst_n=0 in FETCH2 with mem_read=1 -> next sample in IDLE, mem_read=0, all loads 0; release -> FETCH1 after one edge.
REQ-039 ADD imm: opcode=ADD, imm_sel=1, mem_resp on the 2nd FETCH2 cycle -> S_ADD shows alumux_sel=1, load_regfile=1, load_cc=1; back in FETCH1 6 cycles after leaving FETCH1.
REQ-040 BR: opcode=BR, branch_enable=0 -> BR->FETCH1 with no load_pc in BR; branch_enable=1 -> BR_TAKEN with pcmux_sel=1, load_pc=1.
REQ-041 LDR: mem_resp delayed 4 cycles in LDR1 -> mem_read held 5 cycles; LDR2 regfilemux_sel=1, load_regfile=1.
REQ-042 STR: STR2 mem_write=1, mem_byte_enable=2'b11; a stray mem_resp in STR1 is ignored.
REQ-043 Illegal opcode 4'b1101 -> DECODE->FETCH1 with no register loads.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b encodings: instruction opcodes and ALU operation codes.
// Pure type definitions, no logic and no latency.
// No flow control; imported by the control FSM, its interface and the bench.
package lc3b_types;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_AND  = 3'd1,
    ALU_NOT  = 3'd2,
    ALU_PASS = 3'd3,
    ALU_SLL  = 3'd4,
    ALU_SRL  = 3'd5,
    ALU_SRA  = 3'd6
  } lc3b_aluop;

endpackage

// File: rtl/lc3b_control_if.sv
// Control <-> datapath/memory bundle: decoded IR fields and status in, loads/selects/strobes out.
// Purely wiring, zero latency.
// Memory waits are handled by the controller holding its strobe until mem_resp pulses.
interface lc3b_control_if;
  import lc3b_types::*;

  // status from datapath / memory
  lc3b_opcode opcode;
  logic       imm_sel;
  logic       branch_enable;
  logic       mem_resp;

  // register loads
  logic       load_pc;
  logic       load_ir;
  logic       load_regfile;
  logic       load_mar;
  logic       load_mdr;
  logic       load_cc;

  // mux selects
  logic       pcmux_sel;
  logic       storemux_sel;
  logic       alumux_sel;
  logic       regfilemux_sel;
  logic       marmux_sel;
  logic       mdrmux_sel;

  // ALU and memory requests
  lc3b_aluop  aluop;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_byte_enable;

  // controller side
  modport master (
    input  opcode, imm_sel, branch_enable, mem_resp,
    output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
    output pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel,
    output aluop, mem_read, mem_write, mem_byte_enable
  );

  // datapath / memory side
  modport slave (
    output opcode, imm_sel, branch_enable, mem_resp,
    input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
    input  pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel,
    input  aluop, mem_read, mem_write, mem_byte_enable
  );

endinterface

// File: rtl/lc3b_control.sv
// Moore control FSM for the multicycle LC-3b datapath (fetch/decode/execute for ADD/AND/NOT/BR/LDR/STR).
// Outputs decode from state only; an ALU instruction takes 5 cycles FETCH1->FETCH1 with a single-cycle memory.
// Memory states hold mem_read/mem_write steady until mem_resp; mem_resp elsewhere is ignored.
module lc3b_control
  import lc3b_types::*;
(
  input  logic           clk,
  input  logic           rst_n,
  lc3b_control_if.master ctrl
);

  typedef enum logic [3:0] {
    IDLE, FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT, BR, BR_TAKEN,
    CALC_ADDR, LDR1, LDR2, STR1, STR2
  } state_e;

  state_e state_q, state_d;

  // State register; reset drops straight to IDLE even in the middle of a memory wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: sequencing plus opcode dispatch; unsupported opcodes fall back to fetch as NOPs.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = FETCH1;
      FETCH1:   state_d = FETCH2;
      FETCH2:   if (ctrl.mem_resp) state_d = FETCH3;
      FETCH3:   state_d = DECODE;
      DECODE: begin
        case (ctrl.opcode)
          OP_ADD:         state_d = S_ADD;
          OP_AND:         state_d = S_AND;
          OP_NOT:         state_d = S_NOT;
          OP_BR:          state_d = BR;
          OP_LDR, OP_STR: state_d = CALC_ADDR;
          default:        state_d = FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT, BR_TAKEN, LDR2: state_d = FETCH1;
      BR:       state_d = ctrl.branch_enable ? BR_TAKEN : FETCH1;
      CALC_ADDR: begin
        if (ctrl.opcode == OP_LDR)      state_d = LDR1;
        else if (ctrl.opcode == OP_STR) state_d = STR1;
        else                            state_d = FETCH1;
      end
      LDR1:     if (ctrl.mem_resp) state_d = LDR2;
      STR1:     state_d = STR2;
      STR2:     if (ctrl.mem_resp) state_d = FETCH1;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode from current state only; everything idles low with aluop=ADD.
  always_comb begin
    ctrl.load_pc         = 1'b0;
    ctrl.load_ir         = 1'b0;
    ctrl.load_regfile    = 1'b0;
    ctrl.load_mar        = 1'b0;
    ctrl.load_mdr        = 1'b0;
    ctrl.load_cc         = 1'b0;
    ctrl.pcmux_sel       = 1'b0;
    ctrl.storemux_sel    = 1'b0;
    ctrl.alumux_sel      = 1'b0;
    ctrl.regfilemux_sel  = 1'b0;
    ctrl.marmux_sel      = 1'b0;
    ctrl.mdrmux_sel      = 1'b0;
    ctrl.aluop           = ALU_ADD;
    ctrl.mem_read        = 1'b0;
    ctrl.mem_write       = 1'b0;
    ctrl.mem_byte_enable = 2'b00;
    case (state_q)
      FETCH1: begin
        ctrl.marmux_sel = 1'b1;
        ctrl.load_mar   = 1'b1;
        ctrl.load_pc    = 1'b1;
      end
      FETCH2, LDR1: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mdrmux_sel = 1'b1;
        ctrl.load_mdr   = 1'b1;
      end
      FETCH3:   ctrl.load_ir = 1'b1;
      S_ADD, S_AND: begin
        ctrl.aluop        = (state_q == S_AND) ? ALU_AND : ALU_ADD;
        ctrl.alumux_sel   = ctrl.imm_sel;
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
      end
      S_NOT: begin
        ctrl.aluop        = ALU_NOT;
        ctrl.load_regfile = 1'b1;
        ctrl.load_cc      = 1'b1;
      end
      BR_TAKEN: begin
        ctrl.pcmux_sel = 1'b1;
        ctrl.load_pc   = 1'b1;
      end
      CALC_ADDR: begin
        ctrl.alumux_sel = 1'b1;
        ctrl.load_mar   = 1'b1;
      end
      LDR2: begin
        ctrl.regfilemux_sel = 1'b1;
        ctrl.load_regfile   = 1'b1;
        ctrl.load_cc        = 1'b1;
      end
      STR1: begin
        ctrl.storemux_sel = 1'b1;
        ctrl.aluop        = ALU_PASS;
        ctrl.load_mdr     = 1'b1;
      end
      STR2: begin
        ctrl.mem_write       = 1'b1;
        ctrl.mem_byte_enable = 2'b11;
      end
      default: ;
    endcase
  end

endmodule
